seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 108 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed BCD display scanner.
// A prescaler steps through the digit slots. New display data is held
// pending and only applied on the digit 3->0 wrap, so a frame never tears.
// Optional leading-zero suppression drives blanked digits to code F.
module seg_scan_ctrl #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        blank_en,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        frame_start,
    output logic        upd
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_disp;
    logic [15:0]      r_pend;
    logic             r_pend_vld;
    logic             r_frame_start;
    logic             r_upd;

    logic             w_tick;
    logic             w_wrap;
    logic [3:0]       w_nib [4];
    logic [3:0]       w_lead_zero;

    assign w_tick = (r_cnt == CNT_MAX);
    assign w_wrap = w_tick && (r_idx == 2'd3);

    // Prescaler: counts 0..DIV-1 and restarts, one tick per digit slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Digit index advances once per slot and wraps naturally from 3 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Display/pending registers: loads park in pend, applied only at the wrap.
    // A load landing exactly on the wrap bypasses pend and supersedes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp        <= 16'h0000;
            r_pend        <= 16'h0000;
            r_pend_vld    <= 1'b0;
            r_frame_start <= 1'b0;
            r_upd         <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            r_upd         <= w_wrap && (load || r_pend_vld);
            if (w_wrap) begin
                if (load) begin
                    r_disp <= din;
                end else if (r_pend_vld) begin
                    r_disp <= r_pend;
                end
                r_pend_vld <= 1'b0;
            end else if (load) begin
                r_pend     <= din;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Per-digit nibble taps and "this digit and everything above is zero" flags.
    // Digit 0 is never considered leading, so it always shows.
    assign w_lead_zero[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign w_nib[gi] = r_disp[4*gi +: 4];
        end
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign w_lead_zero[gi] = (r_disp[15:4*gi] == '0);
        end
    endgenerate

    // Digit enable and code for the active slot, decoded straight from idx.
    always_comb begin
        an      = 4'b0001 << r_idx;
        bcd_out = w_nib[r_idx];
        if (blank_en && w_lead_zero[r_idx]) begin
            bcd_out = 4'hF;
        end
    end

    assign frame_start = r_frame_start;
    assign upd         = r_upd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl. The driver advances a time-based
// reference model (slot = elapsed cycles / DIV) and queues the expected
// outputs for each clock; an independent monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        blank_en = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        frame_start;
    logic        upd;

    seg_scan_ctrl #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .blank_en   (blank_en),
        .bcd_out    (bcd_out),
        .an         (an),
        .frame_start(frame_start),
        .upd        (upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       fs;
        logic       upd;
        logic [15:0] disp;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset release, shown and waiting data.
    int          m_t = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    bit          m_pend_vld = 1'b0;

    function automatic exp_t model_outputs(logic fs, logic up);
        exp_t e;
        int slot;
        logic [15:0] upper;
        slot  = (m_t / DIV) % 4;
        upper = m_disp >> (4 * slot);
        e.an  = 4'(1 << slot);
        e.bcd = upper[3:0];
        if (blank_en && slot != 0 && upper == 16'h0000) e.bcd = 4'hF;
        e.fs   = fs;
        e.upd  = up;
        e.disp = m_disp;
        return e;
    endfunction

    // One clock of stimulus: drive inputs, advance the model, queue expectations.
    task automatic cycle(input logic r, input logic ld, input logic [15:0] d, input logic be);
        logic fs;
        logic up;
        @(negedge clk);
        rst = r; load = ld; din = d; blank_en = be;
        fs = 1'b0; up = 1'b0;
        if (r) begin
            m_t = 0; m_disp = 16'h0000; m_pend = 16'h0000; m_pend_vld = 1'b0;
        end else begin
            if (m_t % FRAME == FRAME - 1) begin
                fs = 1'b1;
                if (ld) begin
                    m_disp = d; up = 1'b1;
                end else if (m_pend_vld) begin
                    m_disp = m_pend; up = 1'b1;
                end
                m_pend_vld = 1'b0;
            end else if (ld) begin
                m_pend = d; m_pend_vld = 1'b1;
            end
            m_t++;
        end
        if (ld && !r) $display("load din=%h at phase %0d", d, (m_t - 1) % FRAME);
        exp_q.push_back(model_outputs(fs, up));
    endtask

    task automatic idle(input int n, input logic be);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, be);
    endtask

    // Idle until the next clock edge will see the given position in the frame.
    task automatic wait_phase(input int p, input logic be);
        int n = 0;
        while ((m_t % FRAME) != p && n < 3 * FRAME) begin
            cycle(1'b0, 1'b0, 16'h0000, be);
            n++;
        end
        checks++;
        if ((m_t % FRAME) != p) begin
            errors++;
            $display("FAIL wait_phase got %0d want %0d", m_t % FRAME, p);
        end
    endtask

    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t got %h want %h", name, $time, got, want);
        end
    endtask

    // Monitor: every clock the DUT presents a full output set; compare it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("an", an, e.an);
                cmp("bcd_out", bcd_out, e.bcd);
                cmp("frame_start", {3'b000, frame_start}, {3'b000, e.fs});
                cmp("upd", {3'b000, upd}, {3'b000, e.upd});
                if (e.upd) $display("update shown disp=%h", e.disp);
            end
        end
    end

    initial begin
        logic be;
        logic [15:0] d;

        // Reset held two cycles, then scan 1234 unblanked.
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(2 * FRAME + 4, 1'b0);

        // Deferred load during digit 1: old frame completes first.
        wait_phase(DIV + 1, 1'b0);
        cycle(1'b0, 1'b1, 16'h5678, 1'b0);
        idle(FRAME + 6, 1'b0);

        // Leading-zero suppression, then all zeros, then suppression off.
        cycle(1'b0, 1'b1, 16'h0040, 1'b1);
        idle(2 * FRAME, 1'b1);
        cycle(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(2 * FRAME, 1'b1);
        cycle(1'b0, 1'b1, 16'h0040, 1'b0);
        idle(2 * FRAME, 1'b0);
        cycle(1'b0, 1'b1, 16'hA00B, 1'b1);
        idle(2 * FRAME, 1'b1);

        // Load exactly on the wrap tick supersedes the pending value.
        wait_phase(5, 1'b0);
        cycle(1'b0, 1'b1, 16'h1111, 1'b0);
        wait_phase(FRAME - 1, 1'b0);
        cycle(1'b0, 1'b1, 16'h9999, 1'b0);
        idle(FRAME + 3, 1'b0);

        // Reset mid-frame with data pending: nothing shows at the next wrap.
        wait_phase(3, 1'b0);
        cycle(1'b0, 1'b1, 16'hABCD, 1'b0);
        wait_phase(2 * DIV + 1, 1'b0);
        cycle(1'b1, 1'b1, 16'h7777, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Randomized traffic: sparse loads, occasional blank toggles and resets.
        be = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 31) == 0) be = ~be;
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d[15:8] = 8'h00;
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 9) == 0), d, be);
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
